// File: rtl/adder_activity_monitor.sv
// Adder consumer: checks registered sum against the previous cycle's A+B and accumulates
// sum toggle activity over a window. ACTIVITY_MON_INPUTS_EN also counts A/B toggles.
module adder_activity_monitor #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH:0]     sum,
    input  logic               start,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ack,
    output logic [CNT_W-1:0]   toggle_count,
    output logic [CNT_W-1:0]   mismatch_count
);

    // state | meaning
    // IDLE  | waiting for start; last window's counts still visible
    // RUN   | accumulating toggles/mismatches for WINDOW cycles
    // DONE  | result_valid high, counts frozen until result_ack
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int INC_MAX = 3 * WIDTH + 1;
    localparam int INC_W   = $clog2(INC_MAX + 1);
    localparam int SUM_W   = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam int CYC_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW - 1);

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [WIDTH:0]     prev_sum;
    logic [WIDTH-1:0]   a_d, b_d;
    logic               hist_v;

    logic [WIDTH:0]     exp_sum;
    logic [INC_W-1:0]   toggles;
    logic               mismatch_now;
    logic               last_cycle;
    logic [SUM_W-1:0]   toggle_wide;
    logic [CNT_W-1:0]   toggle_sat;
    logic [CNT_W-1:0]   mismatch_sat;

    function automatic logic [INC_W-1:0] popcount(input logic [WIDTH:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            n = n + INC_W'(v[i]);
        end
        return n;
    endfunction

    // Carry kept so an overflowing operand pair still compares against a WIDTH+1 sum.
    assign exp_sum = {1'b0, a_d} + {1'b0, b_d};

`ifdef ACTIVITY_MON_INPUTS_EN
    assign toggles = popcount(sum ^ prev_sum)
                   + popcount({1'b0, A ^ a_d})
                   + popcount({1'b0, B ^ b_d});
`else
    assign toggles = popcount(sum ^ prev_sum);
`endif

    assign mismatch_now = hist_v && (sum != exp_sum);
    assign last_cycle   = (cyc_cnt == CYC_LAST);

    assign toggle_wide  = SUM_W'(toggle_count) + SUM_W'(toggles);
    assign toggle_sat   = (toggle_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : toggle_wide[CNT_W-1:0];
    assign mismatch_sat = (mismatch_now && (mismatch_count != CNT_MAX))
                        ? mismatch_count + CNT_W'(1) : mismatch_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_cycle) state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // History runs in every state so the first RUN cycle compares against real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sum <= '0;
            a_d      <= '0;
            b_d      <= '0;
            hist_v   <= 1'b0;
        end else begin
            prev_sum <= sum;
            a_d      <= A;
            b_d      <= B;
            hist_v   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_count   <= '0;
            mismatch_count <= '0;
            cyc_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        toggle_count   <= '0;
                        mismatch_count <= '0;
                        cyc_cnt        <= '0;
                    end
                end
                RUN: begin
                    toggle_count   <= toggle_sat;
                    mismatch_count <= mismatch_sat;
                    cyc_cnt        <= last_cycle ? '0 : cyc_cnt + CYC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_activity_monitor.sv
// Directed bench for adder_activity_monitor: a WINDOW=3 instance fed by a bench-side
// registered adder (with sum override) and a CNT_W=3/WINDOW=8 instance for saturation.
module tb_adder_activity_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  A, B;
    logic [4:0]  sum;
    logic [4:0]  adder_q;
    logic        force_en;
    logic [4:0]  force_val;
    logic        start, result_ack;
    logic        busy, result_valid;
    logic [15:0] toggle_count, mismatch_count;

    logic [3:0]  sat_a, sat_b;
    logic [4:0]  sat_sum;
    logic        sat_start, sat_ack;
    logic        sat_busy, sat_valid;
    logic [2:0]  sat_toggle, sat_mismatch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) adder_q <= '0;
        else     adder_q <= {1'b0, A} + {1'b0, B};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_sum <= '0;
        else     sat_sum <= ~sat_sum;
    end

    assign sum = force_en ? force_val : adder_q;

    adder_activity_monitor #(.WIDTH(4), .WINDOW(3), .CNT_W(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .A              (A),
        .B              (B),
        .sum            (sum),
        .start          (start),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ack     (result_ack),
        .toggle_count   (toggle_count),
        .mismatch_count (mismatch_count)
    );

    adder_activity_monitor #(.WIDTH(4), .WINDOW(8), .CNT_W(3)) u_sat (
        .clk            (clk),
        .rst            (rst),
        .A              (sat_a),
        .B              (sat_b),
        .sum            (sat_sum),
        .start          (sat_start),
        .busy           (sat_busy),
        .result_valid   (sat_valid),
        .result_ack     (sat_ack),
        .toggle_count   (sat_toggle),
        .mismatch_count (sat_mismatch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; force_en = 1'b0; force_val = '0;
        start = 1'b0; result_ack = 1'b0;
        sat_a = '0; sat_b = '0; sat_start = 1'b0; sat_ack = 1'b0;

        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_toggle", toggle_count, 0);
        check("rst_mismatch", mismatch_count, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // Correct adder: sums 5, 9, 14 -> toggles 2 (0->5) + 2 + 3 = 7
        A = 4'd2; B = 4'd3; start = 1'b1;
        tick();
        check("ok_busy_entry", busy, 1);
        check("ok_valid_entry", result_valid, 0);
        A = 4'd4; B = 4'd5; start = 1'b0;
        tick();
        check("ok_toggle_c1", toggle_count, 2);
        A = 4'd8; B = 4'd6;
        tick();
        check("ok_toggle_c2", toggle_count, 4);
        check("ok_valid_c2", result_valid, 0);
        A = 4'd0; B = 4'd0;
        tick();
        check("ok_valid_done", result_valid, 1);
        check("ok_busy_done", busy, 0);
        check("ok_toggle_done", toggle_count, 7);
        check("ok_mismatch_done", mismatch_count, 0);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("ok_valid_after_ack", result_valid, 0);
        check("ok_toggle_hold_idle", toggle_count, 7);

        // Faulty adder: sum stuck at 0 with A=B=1
        force_en = 1'b1; force_val = '0; A = 4'd1; B = 4'd1; start = 1'b1;
        tick();
        check("bad_busy_entry", busy, 1);
        check("bad_toggle_cleared", toggle_count, 0);
        start = 1'b0;
        tick(); tick(); tick();
        check("bad_valid", result_valid, 1);
        check("bad_mismatch", mismatch_count, 3);
        check("bad_toggle", toggle_count, 0);

        // Handshake: hold without ack; start in DONE is ignored
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) start = 1'b1;
            tick();
            check("hold_valid", result_valid, 1);
            check("hold_mismatch", mismatch_count, 3);
        end
        result_ack = 1'b1; start = 1'b1;
        tick();
        check("ackstart_valid", result_valid, 0);
        check("ackstart_busy", busy, 0);
        check("ackstart_mismatch_hold", mismatch_count, 3);
        result_ack = 1'b0;
        tick();
        check("restart_busy", busy, 1);
        check("restart_mismatch_cleared", mismatch_count, 0);
        start = 1'b0;
        tick();
        check("restart_mismatch_c1", mismatch_count, 1);

        // Reset mid-RUN
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_valid", result_valid, 0);
        check("midrun_rst_mismatch", mismatch_count, 0);
        check("midrun_rst_toggle", toggle_count, 0);
        #2;
        rst = 1'b0;
        tick(); tick();

        // Operand activity: A alternates 0/F, B=0, sum held at 0
        force_en = 1'b1; force_val = '0; A = 4'h0; B = 4'h0;
        tick(); tick();
        A = 4'hF; start = 1'b1;
        tick();
        A = 4'h0; start = 1'b0;
        tick();
        A = 4'hF;
        tick();
        A = 4'h0;
        tick();
        check("inp_valid", result_valid, 1);
        check("inp_mismatch", mismatch_count, 2);
`ifdef ACTIVITY_MON_INPUTS_EN
        check("inp_toggle", toggle_count, 12);
`else
        check("inp_toggle", toggle_count, 0);
`endif

        // Reset mid-DONE
        rst = 1'b1;
        #1;
        check("middone_rst_valid", result_valid, 0);
        check("middone_rst_mismatch", mismatch_count, 0);
        #2;
        rst = 1'b0;
        force_en = 1'b0;
        tick(); tick(); tick();

        // Saturation: 3-bit counters, sum alternating 00000/11111 for 8 cycles
        check("sat_idle_busy", sat_busy, 0);
        sat_start = 1'b1;
        tick();
        check("sat_busy_entry", sat_busy, 1);
        sat_start = 1'b0;
        tick();
        check("sat_toggle_c1", sat_toggle, 5);
        tick();
        check("sat_toggle_c2", sat_toggle, 7);
        repeat (5) tick();
        check("sat_valid_c7", sat_valid, 0);
        tick();
        check("sat_valid", sat_valid, 1);
        check("sat_toggle_final", sat_toggle, 7);
        check("sat_mismatch_final", sat_mismatch, 4);
        sat_ack = 1'b1;
        tick();
        sat_ack = 1'b0;
        check("sat_valid_after_ack", sat_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
